// File: rtl/ysyx_24090012_xbar_if.sv
// AXI4 bus bundle used on every side of the ysyx_24090012 crossbar.
// master/slave carry all five channels; rd_master/rd_slave carry only AR and R,
// for read-only targets such as the CLINT.
interface ysyx_24090012_xbar_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [1:0]  rresp;
  logic [31:0] rdata;
  logic        rlast;
  logic [3:0]  rid;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rresp, rdata, rlast, rid,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rresp, rdata, rlast, rid,
    input  rready
  );

  modport rd_master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rresp, rdata, rlast, rid,
    output rready
  );

  modport rd_slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rresp, rdata, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/ysyx_24090012_xbar.sv
// AXI4 1-to-2 crossbar: routes upstream traffic to the SoC port or the
// read-only CLINT port by address, and answers illegal accesses locally.
// Read and write paths are independent FSMs, one transaction each at a time.
// Optional feature: define YSYX_24090012_XBAR_DECERR_EN to treat addresses
// with addr[31:28]==0 that miss the CLINT as unmapped (answered with DECERR).
module ysyx_24090012_xbar #(
  parameter logic [31:0] CLINT_BASE = 32'h0200_0000,
  parameter logic [31:0] CLINT_MASK = 32'hFFFF_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_24090012_xbar_if.slave           up,
  ysyx_24090012_xbar_if.master          soc,
  ysyx_24090012_xbar_if.rd_master       clint
);

  typedef enum logic [1:0] {R_IDLE, R_SOC, R_CLINT, R_ERR} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SOC, W_ERR} w_state_t;

  r_state_t    r_state;
  logic [3:0]  r_id;
  logic [7:0]  r_len;
  logic [7:0]  r_cnt;
  logic        r_ar_done;
  logic        r_err_arready;
  logic        r_err_rvalid;
  logic        r_err_rlast;

  w_state_t    w_state;
  logic [3:0]  w_id;
  logic [1:0]  w_bresp;
  logic        w_aw_done;
  logic        w_w_done;
  logic        w_err_awready;
  logic        w_err_wready;
  logic        w_err_bvalid;

  logic        ar_clint_hit;
  logic        ar_unmapped;
  logic        aw_clint_hit;
  logic        aw_unmapped;

  assign ar_clint_hit = (up.araddr & CLINT_MASK) == CLINT_BASE;
  assign aw_clint_hit = (up.awaddr & CLINT_MASK) == CLINT_BASE;
`ifdef YSYX_24090012_XBAR_DECERR_EN
  assign ar_unmapped  = (up.araddr[31:28] == 4'h0) && !ar_clint_hit;
  assign aw_unmapped  = (up.awaddr[31:28] == 4'h0) && !aw_clint_hit;
`else
  assign ar_unmapped  = 1'b0;
  assign aw_unmapped  = 1'b0;
`endif

  // Payload fields are broadcast; only the valid/ready pairs are steered
  assign soc.araddr   = up.araddr;
  assign soc.arid     = up.arid;
  assign soc.arlen    = up.arlen;
  assign soc.arsize   = up.arsize;
  assign soc.arburst  = up.arburst;
  assign clint.araddr  = up.araddr;
  assign clint.arid    = up.arid;
  assign clint.arlen   = up.arlen;
  assign clint.arsize  = up.arsize;
  assign clint.arburst = up.arburst;
  assign soc.awaddr   = up.awaddr;
  assign soc.awid     = up.awid;
  assign soc.awlen    = up.awlen;
  assign soc.awsize   = up.awsize;
  assign soc.awburst  = up.awburst;
  assign soc.wdata    = up.wdata;
  assign soc.wstrb    = up.wstrb;
  assign soc.wlast    = up.wlast;

  // Read FSM: decode, track the AR handshake, and sequence local error beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      r_id          <= 4'd0;
      r_len         <= 8'd0;
      r_cnt         <= 8'd0;
      r_ar_done     <= 1'b0;
      r_err_arready <= 1'b0;
      r_err_rvalid  <= 1'b0;
      r_err_rlast   <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (up.arvalid) begin
            r_id      <= up.arid;
            r_len     <= up.arlen;
            r_cnt     <= 8'd0;
            r_ar_done <= 1'b0;
            if (ar_clint_hit) begin
              r_state <= R_CLINT;
            end else if (ar_unmapped) begin
              r_state       <= R_ERR;
              r_err_arready <= 1'b1;
            end else begin
              r_state <= R_SOC;
            end
          end
        end
        R_SOC: begin
          if (up.arvalid && soc.arready && !r_ar_done) r_ar_done <= 1'b1;
          if (soc.rvalid && up.rready && soc.rlast) r_state <= R_IDLE;
        end
        R_CLINT: begin
          if (up.arvalid && clint.arready && !r_ar_done) r_ar_done <= 1'b1;
          if (clint.rvalid && up.rready && clint.rlast) r_state <= R_IDLE;
        end
        R_ERR: begin
          if (r_err_arready) begin
            r_err_arready <= 1'b0;
            r_err_rvalid  <= 1'b1;
            r_err_rlast   <= (r_len == 8'd0);
          end else if (r_err_rvalid && up.rready) begin
            if (r_cnt == r_len) begin
              r_err_rvalid <= 1'b0;
              r_err_rlast  <= 1'b0;
              r_state      <= R_IDLE;
            end else begin
              r_cnt       <= r_cnt + 8'd1;
              r_err_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Read steering: the selected port is wired through, everything else held off
  always_comb begin
    soc.arvalid   = 1'b0;
    soc.rready    = 1'b0;
    clint.arvalid = 1'b0;
    clint.rready  = 1'b0;
    up.arready    = 1'b0;
    up.rvalid     = 1'b0;
    up.rdata      = soc.rdata;
    up.rresp      = soc.rresp;
    up.rlast      = soc.rlast;
    up.rid        = soc.rid;
    case (r_state)
      R_SOC: begin
        soc.arvalid = up.arvalid && !r_ar_done;
        up.arready  = soc.arready && !r_ar_done;
        up.rvalid   = soc.rvalid;
        soc.rready  = up.rready;
      end
      R_CLINT: begin
        clint.arvalid = up.arvalid && !r_ar_done;
        up.arready    = clint.arready && !r_ar_done;
        up.rvalid     = clint.rvalid;
        clint.rready  = up.rready;
        up.rdata      = clint.rdata;
        up.rresp      = clint.rresp;
        up.rlast      = clint.rlast;
        up.rid        = clint.rid;
      end
      R_ERR: begin
        up.arready = r_err_arready;
        up.rvalid  = r_err_rvalid;
        up.rdata   = 32'd0;
        up.rresp   = 2'b11;
        up.rlast   = r_err_rlast;
        up.rid     = r_id;
      end
      default: ;
    endcase
  end

  // Write FSM: decode, track AW/W completion, and sequence local error responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      w_id          <= 4'd0;
      w_bresp       <= 2'b00;
      w_aw_done     <= 1'b0;
      w_w_done      <= 1'b0;
      w_err_awready <= 1'b0;
      w_err_wready  <= 1'b0;
      w_err_bvalid  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (up.awvalid) begin
            w_id      <= up.awid;
            w_aw_done <= 1'b0;
            w_w_done  <= 1'b0;
            if (aw_clint_hit || aw_unmapped) begin
              w_state       <= W_ERR;
              w_err_awready <= 1'b1;
              w_bresp       <= aw_clint_hit ? 2'b10 : 2'b11;
            end else begin
              w_state <= W_SOC;
            end
          end
        end
        W_SOC: begin
          if (up.awvalid && soc.awready && !w_aw_done) w_aw_done <= 1'b1;
          if (up.wvalid && soc.wready && up.wlast && !w_w_done) w_w_done <= 1'b1;
          if (soc.bvalid && up.bready) w_state <= W_IDLE;
        end
        W_ERR: begin
          if (w_err_awready) begin
            w_err_awready <= 1'b0;
            w_err_wready  <= 1'b1;
          end else if (w_err_wready) begin
            if (up.wvalid && up.wlast) begin
              w_err_wready <= 1'b0;
              w_err_bvalid <= 1'b1;
            end
          end else if (w_err_bvalid && up.bready) begin
            w_err_bvalid <= 1'b0;
            w_state      <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Write steering: SoC pass-through or the locally generated error response
  always_comb begin
    soc.awvalid = 1'b0;
    soc.wvalid  = 1'b0;
    soc.bready  = 1'b0;
    up.awready  = 1'b0;
    up.wready   = 1'b0;
    up.bvalid   = 1'b0;
    up.bresp    = soc.bresp;
    up.bid      = soc.bid;
    case (w_state)
      W_SOC: begin
        soc.awvalid = up.awvalid && !w_aw_done;
        up.awready  = soc.awready && !w_aw_done;
        soc.wvalid  = up.wvalid && !w_w_done;
        up.wready   = soc.wready && !w_w_done;
        up.bvalid   = soc.bvalid;
        soc.bready  = up.bready;
      end
      W_ERR: begin
        up.awready = w_err_awready;
        up.wready  = w_err_wready;
        up.bvalid  = w_err_bvalid;
        up.bresp   = w_bresp;
        up.bid     = w_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_24090012_xbar.sv
// Scoreboard bench for ysyx_24090012_xbar: expected R beats and B responses
// are queued when a transaction is issued and checked by independent monitors.
// Set YSYX_24090012_XBAR_DECERR_EN to match the DUT build.
module tb_ysyx_24090012_xbar;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } r_exp_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } b_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_24090012_xbar_if up ();
  ysyx_24090012_xbar_if soc ();
  ysyx_24090012_xbar_if clint ();

  ysyx_24090012_xbar dut (
    .clk   (clk),
    .rst   (rst),
    .up    (up),
    .soc   (soc),
    .clint (clint)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  int     r_beats  = 0;
  int     b_count  = 0;
  int     soc_ar_cnt = 0;
  int     soc_aw_cnt = 0;
  logic   toggle_rready = 1'b0;
  r_exp_t r_q[$];
  b_exp_t b_q[$];
  r_exp_t r_e;
  b_exp_t b_e;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [31:0] d, input logic [1:0] rs, input logic l, input logic [3:0] id);
    r_q.push_back({d, rs, l, id});
  endtask

  // R monitor: every upstream R handshake is checked against the queue
  always @(negedge clk) begin
    if (!rst && up.rvalid && up.rready) begin
      r_beats++;
      if (r_q.size() == 0) begin
        check_output("r_unexpected", 64'd1, 64'd0);
      end else begin
        r_e = r_q.pop_front();
        check_output("r_beat", {up.rdata, up.rresp, up.rlast, up.rid}, r_e);
      end
    end
  end

  // B monitor: every upstream B handshake is checked against the queue
  always @(negedge clk) begin
    if (!rst && up.bvalid && up.bready) begin
      b_count++;
      if (b_q.size() == 0) begin
        check_output("b_unexpected", 64'd1, 64'd0);
      end else begin
        b_e = b_q.pop_front();
        check_output("b_resp", {up.bresp, up.bid}, b_e);
      end
    end
  end

  // Forwarding activity counters
  always @(negedge clk) begin
    if (soc.arvalid) soc_ar_cnt++;
    if (soc.awvalid) soc_aw_cnt++;
  end

  // Upstream rready: constant 1 or toggling every cycle
  initial begin
    up.rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      up.rready = toggle_rready ? ~up.rready : 1'b1;
    end
  end

  // SoC read slave: data = C0DE_0000 + beat index, OKAY response
  logic       s_ar_hs, s_r_hs;
  logic [7:0] s_len, s_beat;
  logic [3:0] s_id;
  initial begin
    soc.arready = 1'b1; soc.rvalid = 1'b0; soc.rdata = 32'd0;
    soc.rresp = 2'b00; soc.rlast = 1'b0; soc.rid = 4'd0;
    s_len = 8'd0; s_beat = 8'd0; s_id = 4'd0;
    forever begin
      @(negedge clk);
      s_ar_hs = soc.arvalid && soc.arready;
      s_r_hs  = soc.rvalid && soc.rready;
      if (s_ar_hs) begin s_len = soc.arlen; s_id = soc.arid; end
      @(posedge clk); #1;
      if (rst) begin
        soc.arready = 1'b1; soc.rvalid = 1'b0; soc.rlast = 1'b0;
      end else if (s_ar_hs) begin
        s_beat = 8'd0; soc.arready = 1'b0; soc.rvalid = 1'b1;
        soc.rdata = 32'hC0DE_0000; soc.rlast = (s_len == 8'd0); soc.rid = s_id;
      end else if (s_r_hs) begin
        if (s_beat == s_len) begin
          soc.rvalid = 1'b0; soc.rlast = 1'b0; soc.arready = 1'b1;
        end else begin
          s_beat++;
          soc.rdata = 32'hC0DE_0000 + {24'd0, s_beat};
          soc.rlast = (s_beat == s_len);
        end
      end
    end
  end

  // CLINT read slave: data = 0x1234 + beat index, OKAY response
  logic       c_ar_hs, c_r_hs;
  logic [7:0] c_len, c_beat;
  logic [3:0] c_id;
  initial begin
    clint.arready = 1'b1; clint.rvalid = 1'b0; clint.rdata = 32'd0;
    clint.rresp = 2'b00; clint.rlast = 1'b0; clint.rid = 4'd0;
    c_len = 8'd0; c_beat = 8'd0; c_id = 4'd0;
    forever begin
      @(negedge clk);
      c_ar_hs = clint.arvalid && clint.arready;
      c_r_hs  = clint.rvalid && clint.rready;
      if (c_ar_hs) begin c_len = clint.arlen; c_id = clint.arid; end
      @(posedge clk); #1;
      if (rst) begin
        clint.arready = 1'b1; clint.rvalid = 1'b0; clint.rlast = 1'b0;
      end else if (c_ar_hs) begin
        c_beat = 8'd0; clint.arready = 1'b0; clint.rvalid = 1'b1;
        clint.rdata = 32'h0000_1234; clint.rlast = (c_len == 8'd0); clint.rid = c_id;
      end else if (c_r_hs) begin
        if (c_beat == c_len) begin
          clint.rvalid = 1'b0; clint.rlast = 1'b0; clint.arready = 1'b1;
        end else begin
          c_beat++;
          clint.rdata = 32'h0000_1234 + {24'd0, c_beat};
          clint.rlast = (c_beat == c_len);
        end
      end
    end
  end

  // SoC write slave: responds OKAY with the captured id once AW and last W are in
  logic        sw_aw_hs, sw_w_hs, sw_wlast, sw_b_hs, sw_got_aw, sw_got_w;
  logic [3:0]  sw_id;
  logic [31:0] sw_wdata, soc_last_wdata;
  initial begin
    soc.awready = 1'b1; soc.wready = 1'b1; soc.bvalid = 1'b0;
    soc.bresp = 2'b00; soc.bid = 4'd0;
    sw_got_aw = 1'b0; sw_got_w = 1'b0; sw_id = 4'd0; soc_last_wdata = 32'd0;
    forever begin
      @(negedge clk);
      sw_aw_hs = soc.awvalid && soc.awready;
      sw_w_hs  = soc.wvalid && soc.wready;
      sw_wlast = soc.wlast;
      sw_wdata = soc.wdata;
      sw_b_hs  = soc.bvalid && soc.bready;
      if (sw_aw_hs) sw_id = soc.awid;
      @(posedge clk); #1;
      if (rst) begin
        soc.awready = 1'b1; soc.wready = 1'b1; soc.bvalid = 1'b0;
        sw_got_aw = 1'b0; sw_got_w = 1'b0;
      end else begin
        if (sw_aw_hs) begin sw_got_aw = 1'b1; soc.awready = 1'b0; end
        if (sw_w_hs) begin
          soc_last_wdata = sw_wdata;
          if (sw_wlast) begin sw_got_w = 1'b1; soc.wready = 1'b0; end
        end
        if (sw_b_hs) begin
          soc.bvalid = 1'b0; soc.awready = 1'b1; soc.wready = 1'b1;
          sw_got_aw = 1'b0; sw_got_w = 1'b0;
        end else if (sw_got_aw && sw_got_w && !soc.bvalid) begin
          soc.bvalid = 1'b1; soc.bresp = 2'b00; soc.bid = sw_id;
        end
      end
    end
  end

  // Issue one AR; reports handshake cycle and which ports saw arvalid
  task automatic apply_stimulus_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                                     output int lat, output logic [1:0] fwd0, output logic [1:0] fwd_hs);
    up.araddr = a; up.arid = id; up.arlen = len; up.arsize = 3'd2; up.arburst = 2'b01;
    up.arvalid = 1'b1;
    lat = -1; fwd0 = 2'b11; fwd_hs = 2'b11;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c == 0) fwd0 = {clint.arvalid, soc.arvalid};
      if (up.arready) begin lat = c; fwd_hs = {clint.arvalid, soc.arvalid}; break; end
    end
    @(posedge clk); #1;
    up.arvalid = 1'b0;
  endtask

  // Issue one AW plus nbeats of W; reports AW handshake cycle and B latency
  task automatic apply_stimulus_write(input logic [31:0] a, input logic [3:0] id, input int nbeats,
                                      input logic [31:0] d0, output int aw_lat, output int b_lat);
    up.awaddr = a; up.awid = id; up.awlen = 8'(nbeats - 1); up.awsize = 3'd2; up.awburst = 2'b01;
    up.awvalid = 1'b1;
    aw_lat = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (up.awready) begin aw_lat = c; break; end
    end
    @(posedge clk); #1;
    up.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      up.wdata = d0 + i; up.wstrb = 4'hF; up.wlast = (i == nbeats - 1); up.wvalid = 1'b1;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (up.wready) break;
      end
      @(posedge clk); #1;
    end
    up.wvalid = 1'b0; up.wlast = 1'b0;
    b_lat = -1;
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      if (up.bvalid) begin b_lat = c; break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_r_beats(input int n, input int bound);
    for (int c = 0; c < bound; c++) begin
      @(posedge clk);
      if (r_beats >= n) return;
    end
    check_output("r_wait_timeout", r_beats, n);
  endtask

  task automatic wait_b(input int n, input int bound);
    for (int c = 0; c < bound; c++) begin
      @(posedge clk);
      if (b_count >= n) return;
    end
    check_output("b_wait_timeout", b_count, n);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int         lat, lat2, awlat, blat, base, snap;
    logic [1:0] f0, fh, f0b, fhb;

    up.arvalid = 0; up.araddr = 0; up.arid = 0; up.arlen = 0; up.arsize = 0; up.arburst = 0;
    up.awvalid = 0; up.awaddr = 0; up.awid = 0; up.awlen = 0; up.awsize = 0; up.awburst = 0;
    up.wvalid = 0; up.wdata = 0; up.wstrb = 0; up.wlast = 0; up.bready = 1'b1;
    clint.awready = 0; clint.wready = 0; clint.bvalid = 0; clint.bresp = 0; clint.bid = 0;

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_output("reset_up_ready", {up.arready, up.awready, up.wready}, 3'b000);
    check_output("reset_up_valid", {up.rvalid, up.bvalid}, 2'b00);
    check_output("reset_soc_out", {soc.arvalid, soc.awvalid, soc.wvalid, soc.rready, soc.bready}, 5'b0);
    check_output("reset_clint_out", {clint.arvalid, clint.rready}, 2'b00);
    @(posedge clk); #1;

    $display("[TB] CLINT read, len 0");
    snap = soc_ar_cnt;
    push_r(32'h0000_1234, 2'b00, 1'b1, 4'd1);
    apply_stimulus_read(32'h0200_BFF8, 4'd1, 8'd0, lat, f0, fh);
    check_output("clint_rd_bubble", f0, 2'b00);
    check_output("clint_rd_lat", lat, 1);
    check_output("clint_rd_fwd", fh, 2'b10);
    wait_r_beats(1, 50);
    #1;
    check_output("clint_rd_no_soc_ar", soc_ar_cnt - snap, 0);

    $display("[TB] SoC 4-beat read with toggling rready");
    @(posedge clk); #1;
    toggle_rready = 1'b1;
    for (int i = 0; i < 4; i++) push_r(32'hC0DE_0000 + i, 2'b00, i == 3, 4'd7);
    apply_stimulus_read(32'h8000_0000, 4'd7, 8'd3, lat, f0, fh);
    check_output("soc_rd_lat", lat, 1);
    check_output("soc_rd_fwd", fh, 2'b01);
    wait_r_beats(5, 100);
    toggle_rready = 1'b0;
    @(negedge clk);
    check_output("soc_rd_idle_after", {soc.rready, up.rvalid}, 2'b00);
    @(posedge clk); #1;

    $display("[TB] CLINT write, 1 beat");
    snap = soc_aw_cnt;
    b_q.push_back({2'b10, 4'd3});
    apply_stimulus_write(32'h0200_4000, 4'd3, 1, 32'hDEAD_BEEF, awlat, blat);
    check_output("clint_wr_aw_lat", awlat, 1);
    check_output("clint_wr_b_lat", blat, 1);
    check_output("clint_wr_no_soc_aw", soc_aw_cnt - snap, 0);
    wait_b(1, 50);
    #1;

    $display("[TB] low-region read, len 3, id 5");
    base = r_beats;
`ifdef YSYX_24090012_XBAR_DECERR_EN
    for (int i = 0; i < 4; i++) push_r(32'd0, 2'b11, i == 3, 4'd5);
`else
    for (int i = 0; i < 4; i++) push_r(32'hC0DE_0000 + i, 2'b00, i == 3, 4'd5);
`endif
    apply_stimulus_read(32'h0100_0000, 4'd5, 8'd3, lat, f0, fh);
    @(negedge clk);
    check_output("low_rd_first_beat", up.rvalid, 1'b1);
    check_output("low_rd_lat", lat, 1);
`ifdef YSYX_24090012_XBAR_DECERR_EN
    check_output("low_rd_fwd", fh, 2'b00);
`else
    check_output("low_rd_fwd", fh, 2'b01);
`endif
    wait_r_beats(base + 4, 50);
    #1;

    $display("[TB] low-region write");
`ifdef YSYX_24090012_XBAR_DECERR_EN
    b_q.push_back({2'b11, 4'd4});
`else
    b_q.push_back({2'b00, 4'd4});
`endif
    apply_stimulus_write(32'h0000_1000, 4'd4, 1, 32'h0000_0055, awlat, blat);
    check_output("low_wr_b_lat", blat, 1);
    wait_b(2, 50);
    #1;

    $display("[TB] low-region read, len 255");
    base = r_beats;
`ifdef YSYX_24090012_XBAR_DECERR_EN
    for (int i = 0; i < 256; i++) push_r(32'd0, 2'b11, i == 255, 4'hA);
`else
    for (int i = 0; i < 256; i++) push_r(32'hC0DE_0000 + i, 2'b00, i == 255, 4'hA);
`endif
    apply_stimulus_read(32'h0000_8000, 4'hA, 8'd255, lat, f0, fh);
    wait_r_beats(base + 256, 400);
    @(negedge clk);
    check_output("len255_done", {up.rvalid, r_beats - base}, {1'b0, 32'd256});
    @(posedge clk); #1;

    $display("[TB] concurrent SoC write and CLINT read");
    base = r_beats;
    b_q.push_back({2'b00, 4'd9});
    push_r(32'h0000_1234, 2'b00, 1'b1, 4'd2);
    fork
      apply_stimulus_write(32'h8000_1000, 4'd9, 2, 32'hAA00_0000, awlat, blat);
      apply_stimulus_read(32'h0200_0010, 4'd2, 8'd0, lat2, f0b, fhb);
    join
    check_output("conc_wr_aw_lat", awlat, 1);
    check_output("conc_wr_b_lat", blat, 1);
    check_output("conc_rd_lat", lat2, 1);
    check_output("conc_rd_fwd", fhb, 2'b10);
    wait_b(3, 50);
    wait_r_beats(base + 1, 50);
    #1;
    check_output("conc_wr_data", soc_last_wdata, 32'hAA00_0001);

    $display("[TB] reset during beat 2 of SoC read");
    @(posedge clk); #1;
    base = r_beats;
    for (int i = 0; i < 4; i++) push_r(32'hC0DE_0000 + i, 2'b00, i == 3, 4'd6);
    apply_stimulus_read(32'h8000_2000, 4'd6, 8'd3, lat, f0, fh);
    wait_r_beats(base + 1, 50);
    #2 rst = 1'b1;
    @(negedge clk);
    check_output("rst_up_rvalid", up.rvalid, 1'b0);
    check_output("rst_soc_rready", soc.rready, 1'b0);
    check_output("rst_soc_arvalid", soc.arvalid, 1'b0);
    r_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    base = r_beats;
    push_r(32'hC0DE_0000, 2'b00, 1'b1, 4'd1);
    apply_stimulus_read(32'h8000_3000, 4'd1, 8'd0, lat, f0, fh);
    check_output("post_rst_lat", lat, 1);
    wait_r_beats(base + 1, 50);
    #1;

    repeat (3) @(posedge clk);
    check_output("r_queue_empty", r_q.size(), 0);
    check_output("b_queue_empty", b_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
